instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate generator and decode logic.
- Owns the program counter and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Presents one 32-bit instruction plus its PC to the consumer with a valid/ready handshake.
- Accepts taken-branch/jump redirects, computed downstream from the generated immediate, and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word-aligned request address (= pc while requesting).
- imem_gnt  in  1  memory accepts request when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; exactly one per granted request, in order, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- instr_valid  out  1  instruction/PC outputs valid.
- instr_ready  in  1  consumer accepts when instr_valid && instr_ready.
- instr  out  32  fetched instruction (feeds immediate generator/decode).
- instr_pc  out  32  address of instr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC; bits [1:0] ignored (forced 00).

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, kill=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=0.
- Max one outstanding memory request.
- States:
  - IDLE: no request; next cycle → REQ. A redirect in IDLE loads pc=target, still → REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - On gnt: req_pc<=pc, → WAIT.
    - imem_req stays high until granted; imem_addr stays stable.
  - WAIT: imem_req=0.
    - On rvalid with kill=0: instr<=rdata, instr_pc<=req_pc, pc<=req_pc+4, instr_valid<=1, → HOLD.
    - On rvalid with kill=1: data dropped, kill<=0, → REQ.
  - HOLD: instr_valid=1, instr/instr_pc stable.
    - On instr_ready: instr_valid<=0, → REQ.
- Redirect has highest priority; target = {redirect_target[31:2],2'b00}.
  - REQ without gnt: pc<=target, stay REQ; next cycle's imem_addr = target.
  - REQ with gnt same cycle: old-pc request is in flight; pc<=target, kill<=1, → WAIT.
  - WAIT without rvalid: pc<=target, kill<=1.
  - WAIT with rvalid same cycle: response discarded regardless of kill, pc<=target, kill<=0, → REQ.
  - HOLD, with or without instr_ready: instr_valid<=0 next cycle, pc<=target, → REQ; held instruction is dropped.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with gnt and rvalid at minimum latency and ready held high.
- Output behaviour:
  - instr_valid, instr, instr_pc are registered.
  - imem_req and imem_addr are decoded from state/pc with no input-to-output combinational path.
  - instr_valid never drops without a handshake except on redirect or reset.
- Reset mid-WAIT: the pending response may still arrive after reset. It arrives in IDLE/REQ and is ignored; rvalid outside WAIT is always ignored.

Optional Feature:
- Macro: IFETCH_STALL_CNT_EN.
- Defined: adds output port stall_cnt (32 bits), reset to 0.
  - Increments by 1 every cycle in REQ with !imem_gnt, or in WAIT with !imem_rvalid.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, ready=1, memory returns 32'h00A00093 @0 and 32'h00000013 @4 → instr_valid with instr_pc=0/instr=32'h00A00093, then instr_pc=4/instr=32'h00000013; imem_addr sequence 0,4,8.
- Backpressure: ready=0 for 5 cycles in HOLD → instr/instr_pc stable, imem_req=0 throughout; ready=1 → next imem_addr = instr_pc+4.
- Redirect in WAIT (addr 0x10 in flight, redirect_target=0x103) → response for 0x10 dropped (no instr_valid); next imem_addr=0x100; instr_pc=0x100 delivered.
- Redirect with gnt same cycle in REQ (pc=0x20, target=0x40) → 0x20 response discarded; next request addr 0x40; also redirect coincident with rvalid → data dropped, → REQ at target.
- Wrap and memory stall: redirect to 0xFFFF_FFFC, gnt delayed 3 cycles → imem_addr held 0xFFFF_FFFC until gnt; following request addr 0x0000_0000. With IFETCH_STALL_CNT_EN, stall_cnt increases by exactly 3 from the gnt delay.
- Async reset asserted in HOLD and in WAIT → outputs zero immediately without a clock; late rvalid after reset ignored; first request addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/gnt + rvalid memory port and hands instructions downstream with valid/ready.
// Taken-branch redirects replace the PC, and any fetch already in flight is discarded.
// Optional build macro IFETCH_STALL_CNT_EN adds the stall_cnt output, a saturating
// count of cycles spent waiting on instruction memory.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] RESET_PC_W = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            instr_valid_q;
    logic            kill_q;
    logic [XLEN-1:0] redir_pc;
    logic            unused_redir_lsbs;

    // Redirect targets are word aligned; the two low bits are dropped.
    assign redir_pc          = {redirect_target[XLEN-1:2], 2'b00};
    assign unused_redir_lsbs = ^redirect_target[1:0];

    // Memory request decoded from registered state only.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = imem_req ? pc_q : '0;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    // Fetch FSM; redirect takes priority over every other event in each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC_W;
            req_pc_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc;
                    end
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc_q <= pc_q;
                        state_q  <= S_WAIT;
                        if (redirect_valid) begin
                            pc_q   <= redir_pc;
                            kill_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pc_q <= redir_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_q    <= redir_pc;
                            state_q <= S_REQ;
                        end else if (kill_q) begin
                            state_q <= S_REQ;
                        end else begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= req_pc_q;
                            pc_q          <= req_pc_q + PC_STEP;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc_q   <= redir_pc;
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= redir_pc;
                        state_q       <= S_REQ;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_cycle;

    assign stall_cycle = ((state_q == S_REQ) && !imem_gnt) ||
                         ((state_q == S_WAIT) && !imem_rvalid);
    assign stall_cnt   = stall_cnt_q;

    // Saturating count of cycles lost to memory grant/response latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect/stall/reset scenarios with literal
// expectations, plus a PC-stream model checked on every cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two real instructions, then an address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0000_0013;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t q[$];
    int    cyc        = 0;
    int    rv_lat     = 1;
    int    stall_req  = 0;
    int    stall_done = 0;

    initial begin
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (imem_rvalid && q.size() > 0) void'(q.pop_front());
            if (!rst && imem_req && imem_gnt) q.push_back('{addr: imem_addr, due: cyc + rv_lat});
            @(posedge clk);
            #1;
            cyc++;
            if (imem_req && stall_done < stall_req) begin
                imem_gnt = 1'b0;
                stall_done++;
            end else begin
                imem_gnt = 1'b1;
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- per-cycle stream model ----------------
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] p_instr, p_pc, p_addr;
        logic        p_valid, p_ready, p_redir, p_req, p_gnt;
        bit          have_prev;
        exp_pc    = RESET_PC;
        have_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc    = RESET_PC;
                have_prev = 0;
            end else begin
                if (have_prev && p_valid && !p_ready && !p_redir) begin
                    check32("m_hold_valid", instr_valid, 1'b1);
                    check32("m_hold_instr", instr, p_instr);
                    check32("m_hold_pc", instr_pc, p_pc);
                end
                if (have_prev && p_req && !p_gnt && !p_redir) begin
                    check32("m_req_held", imem_req, 1'b1);
                    check32("m_addr_stable", imem_addr, p_addr);
                end
                if (instr_valid) begin
                    check32("m_instr_pc", instr_pc, exp_pc);
                    check32("m_instr", instr, mem_word(instr_pc));
                    check32("m_req_excl", imem_req, 1'b0);
                end
                if (imem_req) check32("m_req_addr", imem_addr, exp_pc);
                p_valid = instr_valid;  p_ready = instr_ready; p_redir = redirect_valid;
                p_instr = instr;        p_pc    = instr_pc;
                p_req   = imem_req;     p_gnt   = imem_gnt;    p_addr  = imem_addr;
                have_prev = 1;
                if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
                else if (instr_valid && instr_ready) exp_pc = instr_pc + 32'd4;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, output bit saw_valid);
        int i;
        i = 0;
        saw_valid = 0;
        while (!imem_req && i < 40) begin
            if (instr_valid) saw_valid = 1;
            tick(1);
            i++;
        end
        check32({name, "_req"}, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!instr_valid && i < 40) begin
            tick(1);
            i++;
        end
        check32({name, "_valid"}, instr_valid, 1'b1);
    endtask

    task automatic check_zero_outputs(input string name);
        check32({name, "_valid"}, instr_valid, 1'b0);
        check32({name, "_req"}, imem_req, 1'b0);
        check32({name, "_addr"}, imem_addr, 32'h0);
        check32({name, "_instr"}, instr, 32'h0);
        check32({name, "_pc"}, instr_pc, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit sv;
`ifdef IFETCH_STALL_CNT_EN
        logic [31:0] s0;
`endif
        rst             = 1'b1;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        #2;
        check_zero_outputs("reset");
        tick(2);
        rst = 1'b0;

        // Straight-line fetch with gnt tied high and one-cycle response.
        wait_req("t1a", sv);   check32("t1_addr0", imem_addr, 32'h0);
        wait_valid("t1a");     check32("t1_pc0", instr_pc, 32'h0);
                               check32("t1_instr0", instr, 32'h00A0_0093);
        tick(1);
        wait_req("t1b", sv);   check32("t1_addr4", imem_addr, 32'h4);
        wait_valid("t1b");     check32("t1_pc4", instr_pc, 32'h4);
                               check32("t1_instr4", instr, 32'h0000_0013);
        tick(1);
        wait_req("t1c", sv);   check32("t1_addr8", imem_addr, 32'h8);

        // Consumer backpressure for five cycles.
        instr_ready = 1'b0;
        wait_valid("t2");
        for (int k = 0; k < 5; k++) begin
            check32("t2_valid", instr_valid, 1'b1);
            check32("t2_pc", instr_pc, 32'h8);
            check32("t2_instr", instr, 32'h5A5A_0F07);
            check32("t2_noreq", imem_req, 1'b0);
            tick(1);
        end
        instr_ready = 1'b1;
        tick(1);
        wait_req("t2", sv);    check32("t2_next_addr", imem_addr, 32'hC);

        // Redirect while 0x10 is in flight.
        wait_valid("t3a");     check32("t3_pc_c", instr_pc, 32'hC);
        tick(1);
        wait_req("t3a", sv);   check32("t3_addr10", imem_addr, 32'h10);
        rv_lat = 3;
        tick(1);
        redirect_valid = 1'b1; redirect_target = 32'h103;
        tick(1);
        redirect_valid = 1'b0; rv_lat = 1;
        wait_req("t3b", sv);   check32("t3_dropped", 32'(sv), 32'h0);
                               check32("t3_addr100", imem_addr, 32'h100);
        wait_valid("t3b");     check32("t3_pc100", instr_pc, 32'h100);
                               check32("t3_instr100", instr, 32'h5A5A_0E0F);

        // Redirect from HOLD, then redirect coincident with grant.
        redirect_valid = 1'b1; redirect_target = 32'h20;
        tick(1);
        redirect_valid = 1'b0;
        check32("t4_req20", imem_req, 1'b1);
        check32("t4_addr20", imem_addr, 32'h20);
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        wait_req("t4a", sv);   check32("t4_dropped", 32'(sv), 32'h0);
                               check32("t4_addr40", imem_addr, 32'h40);
        wait_valid("t4a");     check32("t4_pc40", instr_pc, 32'h40);
                               check32("t4_instr40", instr, 32'h5A5A_0F4F);
        // Redirect coincident with the response.
        tick(1);
        check32("t4_addr44", imem_addr, 32'h44);
        tick(1);
        redirect_valid = 1'b1; redirect_target = 32'h80;
        tick(1);
        redirect_valid = 1'b0;
        check32("t4_req80", imem_req, 1'b1);
        check32("t4_addr80", imem_addr, 32'h80);
        check32("t4_novalid", instr_valid, 1'b0);
        wait_valid("t4b");     check32("t4_pc80", instr_pc, 32'h80);
                               check32("t4_instr80", instr, 32'h5A5A_0F8F);

        // Wrap-around with a three-cycle grant stall.
`ifdef IFETCH_STALL_CNT_EN
        s0 = stall_cnt;
`endif
        stall_req      = stall_req + 3;
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check32("t5_req", imem_req, 1'b1);
            check32("t5_addr", imem_addr, 32'hFFFF_FFFC);
            tick(1);
        end
        wait_valid("t5");      check32("t5_pc", instr_pc, 32'hFFFF_FFFC);
                               check32("t5_instr", instr, 32'hA5A5_F0F3);
        tick(1);
        wait_req("t5", sv);    check32("t5_wrap_addr", imem_addr, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
        check32("t5_stall_cnt", stall_cnt, s0 + 32'd3);
`endif

        // Async reset in HOLD.
        wait_valid("t6a");     check32("t6_pc0", instr_pc, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("t6_rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Redirect in IDLE, then async reset while the request is in flight.
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        check32("t6_addr200", imem_addr, 32'h200);
        rv_lat = 3;
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("t6_rst_wait");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rv_lat = 1;
        wait_req("t6b", sv);   check32("t6_first_addr", imem_addr, RESET_PC);
        wait_valid("t6b");     check32("t6_pc_after", instr_pc, RESET_PC);
                               check32("t6_instr_after", instr, 32'h00A0_0093);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
